cdc_handshake_src: RTL and testbench

CDC_HANDSHAKE_SRC -- requirements
Module: cdc_handshake_src

---
 rtl/cdc_handshake_src.sv | 108 ++++++++++
 tb/tb_cdc_handshake_src.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_src.sv
// Source side of a 4-phase req/ack handshake carrying one DATA_W word across a clock boundary.
// The word is registered on acceptance and held stable until the destination has seen req drop.
module cdc_handshake_src #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,     // legal range 2..4
    parameter int TIMEOUT_CYC = 1024   // 0 disables the timeout
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              req,
    output logic [DATA_W-1:0] data_hold,
    input  logic              ack_async,
    output logic              busy,
    output logic              xfer_done,
    output logic              err_timeout,
    input  logic              err_clr
);
    localparam int               CNT_W   = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
    localparam logic             TO_EN   = (TIMEOUT_CYC > 0);

    typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

    state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                ack_s;
    logic                req_q, req_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                hit_q, hit_d;
    logic                err_q, err_d;

    // ack_async lands directly on the first flop; nothing combinational in front of it
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], ack_async};
    end
    assign ack_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    state_d = REQ_HI;
                end
            end
            REQ_HI: if (ack_s) state_d = REQ_LO;
            REQ_LO: begin
                if (!ack_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        req_d = (state_d == REQ_HI);

        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q != IDLE && cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);

        // Fire once when the count first reaches the limit so a cleared flag stays
        // cleared while the counter sits saturated in a long phase.
        hit_d = TO_EN && (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);

        err_d = err_q;
        if (hit_q)        err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            err_q   <= err_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign req         = req_q;
    assign data_hold   = data_q;
    assign xfer_done   = done_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_cdc_handshake_src.sv
// Bench for cdc_handshake_src: timeline model of the handshake plus a word scoreboard,
// a destination responder echoing req after a random delay, and directed corner cases.
module tb_cdc_handshake_src;
    localparam int DW = 32;
    localparam int SS = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst, in_valid, ack_async, err_clr;
    logic [DW-1:0] in_data;
    logic          in_ready, req, busy, xfer_done, err_timeout;
    logic [DW-1:0] data_hold;

    cdc_handshake_src #(.DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .req(req), .data_hold(data_hold),
        .ack_async(ack_async), .busy(busy), .xfer_done(xfer_done),
        .err_timeout(err_timeout), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Model: after acceptance with responder delay d, req is high for L = d+SS+1 edges,
    // ack then takes another L edges to return low, and xfer_done appears 2L edges in.
    logic          m_act;
    int            m_t, m_L;
    logic [DW-1:0] last_acc;
    int            dly, nxt_dly;
    logic [7:0]    hist;
    logic          resp_on, chk_on, acc_flag;
    int            n_edge;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] obs_q[$];
    int            done_e[$];

    function automatic logic m_ready();
        return !m_act || (m_t >= 2 * m_L);
    endfunction

    task automatic tick();
        logic          acc;
        logic [DW-1:0] din;
        acc = !rst && in_valid && m_ready();
        din = in_data;
        @(posedge clk);
        #1;
        acc_flag = acc;
        n_edge++;
        if (rst) begin
            m_act = 1'b0; m_t = 0; last_acc = '0;
        end else if (acc) begin
            dly = nxt_dly; m_act = 1'b1; m_t = 0; m_L = dly + SS + 1; last_acc = din;
            if (chk_on) exp_q.push_back(din);
        end else if (m_act) begin
            m_t++;
        end
        hist = {hist[6:0], req};
        if (resp_on) ack_async = hist[dly];
        if (xfer_done) begin
            obs_q.push_back(data_hold);
            done_e.push_back(n_edge);
        end
        if (chk_on) begin
            chk("req", req, m_act && m_t < m_L);
            chk("busy", busy, m_act && m_t < 2 * m_L);
            chk("in_ready", in_ready, !(m_act && m_t < 2 * m_L));
            chk("xfer_done", xfer_done, m_act && m_t == 2 * m_L);
            chk("data_hold", data_hold, last_acc);
            chk("err_quiet", err_timeout, 1'b0);
            if (xfer_done) begin
                if (exp_q.size() == 0) chk("sb_underflow", 1'b1, 1'b0);
                else                   chk("sb_word", data_hold, exp_q.pop_front());
            end
        end
    endtask

    task automatic wait_done(input int max, output logic got);
        got = 1'b0;
        for (int i = 0; i < max && !got; i++) begin
            tick();
            if (xfer_done) got = 1'b1;
        end
    endtask

    logic [DW-1:0] w [3];
    int            idx, t0;
    logic          got;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; ack_async = 1'b0; err_clr = 1'b0;
        resp_on = 1'b0; chk_on = 1'b0; dly = 0; nxt_dly = 0; hist = '0; n_edge = 0;
        m_act = 1'b0; m_t = 0; m_L = 0; last_acc = '0; acc_flag = 1'b0;
        tick(); tick();
        chk("rst_req", req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_data", data_hold, '0);
        chk("rst_done", xfer_done, 1'b0);
        chk("rst_err", err_timeout, 1'b0);

        // Single transfer, destination echoes req immediately
        rst = 1'b0; resp_on = 1'b1; chk_on = 1'b1;
        in_valid = 1'b1; in_data = 32'hA5A5_0001;
        tick();
        t0 = n_edge;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("single_done_cnt", done_e.size(), 1);
        if (done_e.size() == 1) chk("single_done_edge", done_e[0] - t0, 6);

        // Back-to-back words with in_valid held high
        done_e.delete(); obs_q.delete();
        w[0] = 32'h1; w[1] = 32'h2; w[2] = 32'h3;
        idx = 0; in_valid = 1'b1; in_data = w[0];
        for (int i = 0; i < 30; i++) begin
            tick();
            if (acc_flag) begin
                idx++;
                if (idx < 3) in_data = w[idx];
                else         in_valid = 1'b0;
            end
        end
        chk("b2b_cnt", done_e.size(), 3);
        if (done_e.size() == 3) begin
            // pulses separated by six non-done cycles
            chk("b2b_gap0", done_e[1] - done_e[0], 7);
            chk("b2b_gap1", done_e[2] - done_e[1], 7);
            for (int i = 0; i < 3; i++) chk("b2b_word", obs_q[i], w[i]);
        end

        // Random traffic with random destination latency
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            nxt_dly  = $urandom_range(0, 3);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("rnd_drained", exp_q.size(), 0);

        // Timeout: ack withheld after acceptance
        chk_on = 1'b0; resp_on = 1'b0; ack_async = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        tick();
        in_valid = 1'b0;
        chk("to_req_up", req, 1'b1);
        for (int i = 0; i < 8; i++) tick();
        chk("to_not_yet", err_timeout, 1'b0);
        tick();
        chk("to_set", err_timeout, 1'b1);
        chk("to_req_held", req, 1'b1);
        ack_async = 1'b1;
        tick(); tick(); tick();
        chk("to_req_lo", req, 1'b0);
        ack_async = 1'b0;
        wait_done(10, got);
        chk("to_completes", got, 1'b1);
        chk("to_sticky", err_timeout, 1'b1);
        chk("to_data", data_hold, 32'hDEAD_BEEF);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("to_cleared", err_timeout, 1'b0);

        // err_clr coincident with the set edge, then one edge later
        in_valid = 1'b1; in_data = 32'h24;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        err_clr = 1'b1;
        tick();
        chk("clr_vs_set", err_timeout, 1'b1);
        tick();
        chk("clr_after", err_timeout, 1'b0);
        err_clr = 1'b0;

        // Reset in REQ_LO with ack high
        ack_async = 1'b1;
        tick(); tick(); tick();
        chk("mid_req_lo", req, 1'b0);
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1; in_valid = 1'b1; err_clr = 1'b0;
        tick();
        chk("mid_rst_req", req, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_data", data_hold, '0);
        chk("mid_rst_done", xfer_done, 1'b0);
        rst = 1'b0; ack_async = 1'b0; in_data = 32'h77;
        tick();
        in_valid = 1'b0;
        chk("post_rst_req", req, 1'b1);
        chk("post_rst_data", data_hold, 32'h77);
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_wait", req, 1'b1);

        // Stray ack while idle
        rst = 1'b1; tick(); rst = 1'b0;
        ack_async = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stray_done", xfer_done, 1'b0);
            chk("stray_busy", busy, 1'b0);
        end
        ack_async = 1'b0;
        tick(); tick(); tick();
        in_valid = 1'b1; in_data = 32'h26;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stray_req_wait", req, 1'b1);
            chk("stray_no_done", xfer_done, 1'b0);
        end
        ack_async = 1'b1;
        for (int i = 0; i < 8 && req; i++) tick();
        chk("stray_req_drop", req, 1'b0);
        ack_async = 1'b0;
        wait_done(10, got);
        chk("stray_completes", got, 1'b1);
        chk("stray_data", data_hold, 32'h26);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
